trap_ctrl: RTL

- Trap sequencer between the writeback stage, the CLINT timer and the machine-mode CSR file.
- Decides when an ecall, mret or machine timer interrupt is taken at an instruction boundary.
- Waits for outstanding memory operations to drain, then pulses the CSR file's trap-update inputs for exactly one cycle.
- Flushes and stalls the front end and issues a single redirect to the handler or return address.

---
 rtl/trap_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: captures ecall, mret or timer interrupt at retire,
// waits for the LSU to drain, pulses the CSR file once and redirects fetch.
module trap_ctrl #(
  parameter int XLEN       = 64,
  parameter int INTR_CAUSE = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_wb_valid,
  input  logic [XLEN-1:0] i_wb_pc,
  input  logic [XLEN-1:0] i_wb_npc,
  input  logic            i_wb_ecall,
  input  logic            i_wb_mret,
  input  logic            i_lsu_busy,
  input  logic            i_clint_mtip,
  input  logic            i_csr_mstatus_mie,
  input  logic            i_csr_mie_mtie,
  input  logic [XLEN-1:0] i_csr_mtvec,
  input  logic [XLEN-1:0] i_csr_mepc,
  input  logic            i_redirect_ready,
  output logic            o_csr_timer_intr,
  output logic            o_csr_ecall,
  output logic            o_csr_mret,
  output logic [XLEN-1:0] o_csr_trap_pc,
  output logic            o_flush,
  output logic            o_stall_fetch,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_TRAP, S_REDIRECT} state_t;
  typedef enum logic [1:0] {K_NONE, K_ECALL, K_MRET, K_INTR} kind_t;

  localparam logic [XLEN-1:0] VEC_OFF = XLEN'(4 * INTR_CAUSE);

  state_t          state;
  kind_t           kind;
  logic [XLEN-1:0] lpc;
  logic [XLEN-1:0] redirect_pc_q;
  logic            flush_q;

  logic            int_req;
  logic            cap_ecall;
  logic            cap_mret;
  logic            cap_intr;
  logic [XLEN-1:0] mtvec_base;
  logic [XLEN-1:0] target_pc;

  assign int_req    = i_clint_mtip & i_csr_mstatus_mie & i_csr_mie_mtie;
  // ecall beats mret beats interrupt; a losing interrupt waits for the next retire.
  assign cap_ecall  = i_wb_valid & i_wb_ecall;
  assign cap_mret   = i_wb_valid & ~i_wb_ecall & i_wb_mret;
  assign cap_intr   = i_wb_valid & ~i_wb_ecall & ~i_wb_mret & int_req;
  assign mtvec_base = {i_csr_mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    // NOTE: default first so every path assigns target_pc and no latch is inferred.
    target_pc = mtvec_base;
    case (kind)
      K_MRET: target_pc = i_csr_mepc;
      K_INTR: if (i_csr_mtvec[1:0] == 2'b01) target_pc = mtvec_base + VEC_OFF;
      default: ;
    endcase
  end

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      kind          <= K_NONE;
      lpc           <= '0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cap_ecall || cap_mret || cap_intr) begin
            kind    <= cap_ecall ? K_ECALL : (cap_mret ? K_MRET : K_INTR);
            lpc     <= cap_intr ? i_wb_npc : i_wb_pc;
            flush_q <= 1'b1;
            state   <= i_lsu_busy ? S_DRAIN : S_TRAP;
          end
        end
        S_DRAIN: begin
          if (!i_lsu_busy) state <= S_TRAP;
        end
        S_TRAP: begin
          // Target is frozen here so later CSR writes cannot move a pending redirect.
          redirect_pc_q <= target_pc;
          state         <= S_REDIRECT;
        end
        S_REDIRECT: begin
          if (i_redirect_ready) begin
            redirect_pc_q <= '0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_csr_ecall      = (state == S_TRAP) && (kind == K_ECALL);
  assign o_csr_mret       = (state == S_TRAP) && (kind == K_MRET);
  assign o_csr_timer_intr = (state == S_TRAP) && (kind == K_INTR);
  assign o_csr_trap_pc    = (state == S_TRAP) ? lpc : '0;
  assign o_flush          = flush_q;
  assign o_stall_fetch    = (state != S_IDLE);
  assign o_busy           = (state != S_IDLE);
  assign o_redirect_valid = (state == S_REDIRECT);
  assign o_redirect_pc    = redirect_pc_q;

endmodule
